// File: rtl/pe_fifo.sv
// pe_fifo: first-word-fall-through operand FIFO between the NoC and the PE datapath.
// All state changes on the falling clock edge; reset is asynchronous and active-high.
// The internal occupancy count is the single source for full/empty and the handshakes;
// push_fire/pop_fire are one-cycle registered strobes feeding the PE occupancy counter.
module pe_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  push_fire,
  output logic                  pop_fire
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_accept;
  logic                  pop_accept;

  // Flags and handshakes come straight from the count; the head word falls through unregistered
  always_comb begin
    full        = (count == FULL_COUNT);
    empty       = (count == '0);
    push_ready  = !full;
    pop_valid   = !empty;
    push_accept = push_valid && push_ready;
    pop_accept  = pop_valid && pop_ready;
    pop_data    = empty ? '0 : mem[rd_ptr];
  end

  // Storage array is written on accepted pushes only and is deliberately left uncleared by reset
  always_ff @(negedge clk) begin
    if (push_accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and strobes; the pointers wrap naturally at DEPTH, the count never wraps
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      push_fire <= 1'b0;
      pop_fire  <= 1'b0;
    end else begin
      push_fire <= push_accept;
      pop_fire  <= pop_accept;
      if (push_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_accept, pop_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_fifo.sv
// tb_pe_fifo: scoreboard bench for pe_fifo. The driver keeps a queue model of the FIFO and
// queues the expected post-edge state and accepted words; a posedge monitor compares them.
module tb_pe_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    int tag;
    int cnt;
    bit pf;
    bit qf;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push_fire;
  logic          pop_fire;

  int            checks;
  int            errors;
  int            cyc;
  bit            mon_en;
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] data_q[$];
  exp_t          state_q[$];
  exp_t          cur;
  logic [DW-1:0] head;

  pe_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_data(push_data),
    .pop_valid(pop_valid),
    .pop_ready(pop_ready),
    .pop_data(pop_data),
    .count(count),
    .full(full),
    .empty(empty),
    .push_fire(push_fire),
    .pop_fire(pop_fire)
  );

  // Free-running clock; the DUT acts on the falling edge
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Falling-edge counter used to tag each expected post-edge state
  initial cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the queue model by what the coming falling edge should do
  task automatic applyStimulus(input bit pv, input logic [DW-1:0] pd, input bit pr);
    bit push_acc;
    bit pop_acc;
    @(negedge clk);
    #1;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    pop_acc    = pr && (ref_q.size() > 0);
    push_acc   = pv && (ref_q.size() < DEPTH);
    if (pop_acc) void'(ref_q.pop_front());
    if (push_acc) begin
      ref_q.push_back(pd);
      data_q.push_back(pd);
    end
    state_q.push_back('{tag: cyc + 1, cnt: ref_q.size(), pf: push_acc, qf: pop_acc});
  endtask

  // Monitor on the rising edge: compare the state left by the last falling edge, then score any pop about to happen
  always @(posedge clk) begin
    if (mon_en) begin
      if (state_q.size() > 0 && state_q[0].tag == cyc) begin
        cur = state_q.pop_front();
        checkOutput("count", int'(count), cur.cnt);
        checkOutput("full", int'(full), int'(cur.cnt == DEPTH));
        checkOutput("empty", int'(empty), int'(cur.cnt == 0));
        checkOutput("push_ready", int'(push_ready), int'(cur.cnt != DEPTH));
        checkOutput("pop_valid", int'(pop_valid), int'(cur.cnt != 0));
        checkOutput("push_fire", int'(push_fire), int'(cur.pf));
        checkOutput("pop_fire", int'(pop_fire), int'(cur.qf));
        if (cur.cnt == 0) checkOutput("pop_data_empty", int'(pop_data), 0);
      end
      if (pop_valid && pop_ready) begin
        if (data_q.size() == 0) begin
          checkOutput("pop_underflow", 1, 0);
        end else begin
          head = data_q.pop_front();
          checkOutput("pop_data", int'(pop_data), int'(head));
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic and a mid-cycle reset
  initial begin
    checks     = 0;
    errors     = 0;
    mon_en     = 1'b1;
    reset      = 1'b1;
    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
    #3;
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_push_ready", int'(push_ready), 1);
    checkOutput("rst_pop_valid", int'(pop_valid), 0);
    checkOutput("rst_pop_data", int'(pop_data), 0);
    reset = 1'b0;

    // Fill to full, then an ignored fifth push
    applyStimulus(1'b1, 16'h0011, 1'b0);
    applyStimulus(1'b1, 16'h0022, 1'b0);
    applyStimulus(1'b1, 16'h0033, 1'b0);
    applyStimulus(1'b1, 16'h0044, 1'b0);
    applyStimulus(1'b1, 16'h0055, 1'b0);
    // Drain in order, then one idle cycle so pop_fire must drop
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    // Simultaneous push and pop with two entries held
    applyStimulus(1'b1, 16'h0A0A, 1'b0);
    applyStimulus(1'b1, 16'h0B0B, 1'b0);
    applyStimulus(1'b1, 16'h0C0C, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    // Full state: push and pop together only pops, the following push refills
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Streaming across the pointer wrap with occupancy held low
    applyStimulus(1'b1, 16'h2000, 1'b0);
    for (int i = 1; i < 10; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);

    // Randomized traffic in phases biased toward filling, balanced and draining
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 120; i++) begin
        applyStimulus(bit'($urandom_range(0, 99) < (ph == 0 ? 80 : (ph == 1 ? 50 : 25))),
                      16'($urandom),
                      bit'($urandom_range(0, 99) < (ph == 0 ? 25 : (ph == 1 ? 50 : 80))));
      end
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Three pushes, then an asynchronous reset between clock edges
    applyStimulus(1'b1, 16'h3001, 1'b0);
    applyStimulus(1'b1, 16'h3002, 1'b0);
    applyStimulus(1'b1, 16'h3003, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_count", int'(count), 3);
    checkOutput("pre_reset_pending", state_q.size(), 0);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    checkOutput("mid_rst_count", int'(count), 0);
    checkOutput("mid_rst_empty", int'(empty), 1);
    checkOutput("mid_rst_pop_data", int'(pop_data), 0);
    checkOutput("mid_rst_push_fire", int'(push_fire), 0);
    checkOutput("mid_rst_pop_fire", int'(pop_fire), 0);
    checkOutput("mid_rst_push_ready", int'(push_ready), 1);
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    ref_q.delete();
    data_q.delete();
    state_q.delete();
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // FIFO must work normally after the reset
    applyStimulus(1'b1, 16'h1234, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("end_pending_states", state_q.size(), 0);
    checkOutput("end_pending_words", data_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_fifo.md
Name: pe_fifo

Overview:
- Small first-word-fall-through FIFO that buffers operand words (ifmap, filter or psum) arriving from the NoC before they reach the PE datapath.
- Valid/ready handshakes on both sides.
- Exports one-cycle push/pop strobes so the PE's occupancy counter can track it: push strobe drives the counter's inc input, pop strobe drives its dec input.
- Also keeps its own internal occupancy count, which is the authority for full/empty.

Parameters:
- DATA_WIDTH, 16, width of each stored word.
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_WIDTH, 2, log2(DEPTH); must be set consistently with DEPTH.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-high; clears pointers, count and strobes immediately.
- push_valid  input  1  upstream has a word on push_data.
- push_ready  output  1  FIFO can accept a word; equals !full.
- push_data  input  DATA_WIDTH  word to write.
- pop_valid  output  1  head word available; equals !empty.
- pop_ready  input  1  downstream consumes the head word.
- pop_data  output  DATA_WIDTH  head word; forced to 0 while empty.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- push_fire  output  1  registered strobe: a push was accepted at the last falling edge.
- pop_fire  output  1  registered strobe: a pop was accepted at the last falling edge.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - wr_ptr, rd_ptr and count go to 0; push_fire and pop_fire go to 0.
  - Resulting outputs: empty=1, full=0, push_ready=1, pop_valid=0, pop_data=0.
  - Storage contents are not cleared and are unobservable after reset.
- Storage: DEPTH x DATA_WIDTH register array, written on the falling edge.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Push accept: push_valid && push_ready, sampled at the falling edge. Effects:
  - mem[wr_ptr] <= push_data.
  - wr_ptr increments.
- Pop accept: pop_valid && pop_ready at the falling edge. Effect: rd_ptr increments.
- Count update at each falling edge:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - Never wraps: a push is impossible when full and a pop is impossible when empty.
- pop_data: combinational read of mem[rd_ptr] when !empty, else 0 (first-word fall-through).
  - A word pushed at edge N is visible on pop_data and pop_valid right after edge N.
  - Zero-cycle bypass of an empty FIFO is not supported.
- Full:
  - push_ready=0 even if pop_ready=1 in the same cycle; no push-through while full.
  - A pop at the edge makes push_ready=1 after that edge.
- Empty: pop_valid=0 and pop_ready is ignored.
- Simultaneous push and pop when neither full nor empty:
  - Both occur and count is unchanged.
  - The head word is read before the overwrite; wr_ptr != rd_ptr is guaranteed because count < DEPTH.
- Strobes:
  - push_fire and pop_fire are registered on the same falling edge as the accept and last exactly one clk period.
  - Both high together when push and pop coincide.
- Flag timing: full, empty, push_ready and pop_valid are pure functions of count, with no extra registering.
- Latency: write-to-read is 1 falling edge.
- Throughput: one push and one pop per cycle.

Test Plan:
- Reset behaviour: assert reset mid-cycle while count=3 → count=0, empty=1, pop_data=0, push_fire=pop_fire=0 immediately, with no wait for a clk edge.
- Fill to full: push 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles with pop_ready=0 → count 1,2,3,4, then full=1 and push_ready=0. A fifth push of 0x0055 is ignored and count stays 4.
- Drain in order: from the full state above, pop_ready=1 for 4 cycles → pop_data shows 0x0011, 0x0022, 0x0033, 0x0044 in that order. Afterwards empty=1 and pop_data=0. pop_fire is high for exactly 4 edges.
- Simultaneous push and pop: count=2 with head 0x0A0A, push 0x0C0C with pop_ready=1 → count stays 2, push_fire=pop_fire=1, and the new head is the second entry.
- Full-state simultaneity: count=4, push_valid=1, pop_ready=1 → only the pop occurs, count=3, push_fire=0. The next cycle's push is accepted and count returns to 4.
- Pointer wrap: push/pop 10 words in a streaming pattern holding count at 1–2 → all 10 words come out in order across the pointer wrap, and count never exceeds 2.
